// File: rtl/prng_ks_pkg.sv
// Shared types and helpers for the PRNG keystream packer.
//   MantW   : mantissa bits taken from each float32 PRNG output
//   state_e : packer frame state (idle, discarding transient, running)
//   mant()  : extract the mantissa field of a float32 word
package prng_ks_pkg;

  localparam int unsigned MantW = 23;

  typedef enum logic [1:0] {
    StIdle,
    StDisc,
    StRun
  } state_e;

  function automatic logic [MantW-1:0] mant(input logic [31:0] x);
    return x[MantW-1:0];
  endfunction

endpackage

// File: rtl/ks_bit_fifo.sv
// Left-aligned bit accumulator: bits enter behind the existing contents and
// leave from the top, OUT_W at a time. Push and pop may occur in the same cycle.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clr_i          : drop all contents (frame start)
//   push_i         : append push_data_i (IN_W bits, MSB first); caller gates with fits_o
//   pop_i          : remove the oldest OUT_W bits; caller gates with can_pop_o
//   data_o         : oldest OUT_W bits, first bit at MSB (registered)
//   can_pop_o      : at least OUT_W bits held
//   fits_o         : an IN_W push fits, taking this cycle's pop into account
module ks_bit_fifo #(
  parameter int unsigned ACC_W = 128,
  parameter int unsigned IN_W  = 69,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [IN_W-1:0]  push_data_i,
  input  logic             pop_i,
  output logic [OUT_W-1:0] data_o,
  output logic             can_pop_o,
  output logic             fits_o
);

  localparam int unsigned CntW = $clog2(ACC_W + 1);

  logic [ACC_W-1:0] acc_q, acc_d, acc_shift;
  logic [CntW-1:0]  count_q, count_d, count_rem;

  always_comb begin
    acc_shift = pop_i ? (acc_q << OUT_W) : acc_q;
    count_rem = pop_i ? (count_q - CntW'(OUT_W)) : count_q;
    fits_o    = ({1'b0, count_rem} + (CntW+1)'(IN_W)) <= (CntW+1)'(ACC_W);
    acc_d     = acc_shift;
    count_d   = count_rem;
    // Bits below count are always zero, so the new sample can be OR-ed in place.
    if (push_i) begin
      acc_d   = acc_shift | ({push_data_i, {(ACC_W-IN_W){1'b0}}} >> count_rem);
      count_d = count_rem + CntW'(IN_W);
    end
    if (clr_i) begin
      acc_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign data_o    = acc_q[ACC_W-1 -: OUT_W];
  assign can_pop_o = count_q >= CntW'(OUT_W);

endmodule

// File: rtl/prng_keystream_packer.sv
// Consumes PRNG result triples, drops the first DISCARD samples of a frame,
// packs the three mantissas MSB-first and emits a framed OUT_W-bit keystream.
//   clk, reset         : clock, synchronous active-high reset
//   start, num_bytes   : frame start pulse and length in words (latched in idle)
//   busy               : frame in progress
//   prng_valid, r1..r3 : PRNG result strobe and float outputs (no backpressure)
//   ks_valid/ready     : keystream handshake; ks_data oldest bits; ks_last final word
//   overflow           : sticky, a sample arrived in run with no room and was dropped
module prng_keystream_packer
  import prng_ks_pkg::*;
#(
  parameter int unsigned PRECISION = 32,
  parameter int unsigned MANT_W    = MantW,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned ACC_W     = 128,
  parameter int unsigned DISCARD   = 16,
  parameter int unsigned CNT_W     = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_bytes,
  output logic                 busy,
  input  logic                 prng_valid,
  input  logic [PRECISION-1:0] prng_r1,
  input  logic [PRECISION-1:0] prng_r2,
  input  logic [PRECISION-1:0] prng_r3,
  output logic                 ks_valid,
  input  logic                 ks_ready,
  output logic [OUT_W-1:0]     ks_data,
  output logic                 ks_last,
  output logic                 overflow
);

  localparam int unsigned InW   = 3 * MANT_W;
  localparam int unsigned DiscW = (DISCARD > 1) ? $clog2(DISCARD + 1) : 1;

  state_e           state_q, state_d;
  logic [DiscW-1:0] disc_cnt_q, disc_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] num_bytes_q, num_bytes_d;
  logic             overflow_q, overflow_d;

  logic             clr, push, drop, fire, can_pop, fits;
  logic [InW-1:0]   sample;
  logic             unused_hi;

  assign sample    = {prng_r1[MANT_W-1:0], prng_r2[MANT_W-1:0], prng_r3[MANT_W-1:0]};
  assign unused_hi = ^{prng_r1[PRECISION-1:MANT_W], prng_r2[PRECISION-1:MANT_W],
                       prng_r3[PRECISION-1:MANT_W]};

  // All ks_* outputs derive from registered state only.
  assign busy     = (state_q != StIdle);
  assign ks_valid = (state_q == StRun) && can_pop;
  assign ks_last  = ks_valid && (word_cnt_q == (num_bytes_q - CNT_W'(1)));
  assign fire     = ks_valid && ks_ready;
  assign push     = (state_q == StRun) && prng_valid && fits;
  assign drop     = (state_q == StRun) && prng_valid && !fits;
  assign overflow = overflow_q;

  ks_bit_fifo #(
    .ACC_W (ACC_W),
    .IN_W  (InW),
    .OUT_W (OUT_W)
  ) u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .clr_i       (clr),
    .push_i      (push),
    .push_data_i (sample),
    .pop_i       (fire),
    .data_o      (ks_data),
    .can_pop_o   (can_pop),
    .fits_o      (fits)
  );

  always_comb begin
    state_d     = state_q;
    disc_cnt_d  = disc_cnt_q;
    word_cnt_d  = word_cnt_q;
    num_bytes_d = num_bytes_q;
    overflow_d  = overflow_q;
    clr         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (num_bytes != '0)) begin
          clr         = 1'b1;
          disc_cnt_d  = '0;
          word_cnt_d  = '0;
          overflow_d  = 1'b0;
          num_bytes_d = num_bytes;
          state_d     = (DISCARD == 0) ? StRun : StDisc;
        end
      end
      StDisc: begin
        if (prng_valid) begin
          disc_cnt_d = disc_cnt_q + DiscW'(1);
          if (disc_cnt_q == DiscW'(DISCARD - 1)) state_d = StRun;
        end
      end
      StRun: begin
        if (fire) word_cnt_d = word_cnt_q + CNT_W'(1);
        if (drop) overflow_d = 1'b1;
        if (fire && ks_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      disc_cnt_q  <= '0;
      word_cnt_q  <= '0;
      num_bytes_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      disc_cnt_q  <= disc_cnt_d;
      word_cnt_q  <= word_cnt_d;
      num_bytes_q <= num_bytes_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_prng_keystream_packer.sv
module tb_prng_keystream_packer;
  localparam int Disc = 2;
  localparam int AccW = 128;
  localparam int MW   = 23;
  localparam int OW   = 8;

  logic        clk = 1'b0;
  logic        reset, start, busy, prng_valid, ks_valid, ks_ready, ks_last, overflow;
  logic [23:0] num_bytes;
  logic [31:0] prng_r1, prng_r2, prng_r3;
  logic [7:0]  ks_data;

  always #5 clk = ~clk;

  prng_keystream_packer #(
    .PRECISION (32),
    .MANT_W    (MW),
    .OUT_W     (OW),
    .ACC_W     (AccW),
    .DISCARD   (Disc),
    .CNT_W     (24)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_bytes  (num_bytes),
    .busy       (busy),
    .prng_valid (prng_valid),
    .prng_r1    (prng_r1),
    .prng_r2    (prng_r2),
    .prng_r3    (prng_r3),
    .ks_valid   (ks_valid),
    .ks_ready   (ks_ready),
    .ks_data    (ks_data),
    .ks_last    (ks_last),
    .overflow   (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame flags plus the pending keystream as a plain bit queue.
  bit   m_q[$];
  bit   m_busy = 0;
  int   m_disc_left = 0;
  int   m_nb = 0;
  int   m_words = 0;
  bit   m_ovf = 0;
  bit   m_ok = 0;
  logic [7:0] got_q[$];

  function automatic bit m_valid();
    return m_busy && (m_disc_left == 0) && (m_q.size() >= OW);
  endfunction

  function automatic logic [7:0] m_head();
    logic [7:0] d = '0;
    for (int i = 0; i < OW; i++) if (i < m_q.size()) d[OW-1-i] = m_q[i];
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst_v, input bit st_v, input int nb_v, input bit pv_v,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input bit rdy_v);
    bit mv, fire, last;
    mv   = m_valid();
    fire = mv && rdy_v;
    last = mv && (m_words == m_nb - 1);
    if (m_ok) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("ks_valid", 32'(ks_valid), 32'(mv));
      chk("ks_last", 32'(ks_last), 32'(last));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (mv) chk("ks_data", 32'(ks_data), 32'(m_head()));
    end
    if (ks_valid === 1'b1 && rdy_v) got_q.push_back(ks_data);
    reset = rst_v; start = st_v; num_bytes = 24'(nb_v); prng_valid = pv_v;
    prng_r1 = a; prng_r2 = b; prng_r3 = c; ks_ready = rdy_v;
    if (rst_v) begin
      m_q.delete(); m_busy = 0; m_disc_left = 0; m_nb = 0; m_words = 0; m_ovf = 0; m_ok = 1;
    end else if (!m_busy) begin
      if (st_v && nb_v != 0) begin
        m_busy = 1; m_disc_left = Disc; m_nb = nb_v; m_words = 0; m_ovf = 0; m_q.delete();
      end
    end else if (m_disc_left > 0) begin
      if (pv_v) m_disc_left--;
    end else begin
      if (fire) begin
        for (int i = 0; i < OW; i++) void'(m_q.pop_front());
        m_words++;
      end
      if (pv_v) begin
        if (m_q.size() + 3 * MW <= AccW) begin
          for (int i = MW - 1; i >= 0; i--) m_q.push_back(a[i]);
          for (int i = MW - 1; i >= 0; i--) m_q.push_back(b[i]);
          for (int i = MW - 1; i >= 0; i--) m_q.push_back(c[i]);
        end else m_ovf = 1;
      end
      if (fire && last) m_busy = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy_v);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, rdy_v);
  endtask

  task automatic junk(input bit rdy_v);
    step(0, 0, 0, 1, $urandom, $urandom, $urandom, rdy_v);
  endtask

  localparam logic [31:0] SA = 32'h3F7FFFFF, SB = 32'h3F000000, SC = 32'h3F2AAAAA;
  logic [7:0] t2_words [9] = '{8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h01, 8'h55, 8'h55, 8'h57};

  initial begin
    reset = 1; start = 0; num_bytes = 0; prng_valid = 0; ks_ready = 0;
    prng_r1 = 0; prng_r2 = 0; prng_r3 = 0;
    @(negedge clk);

    // T1: reset with prng_valid toggling
    for (int i = 0; i < 3; i++) step(1, 0, 0, i[0], $urandom, $urandom, $urandom, 0);
    idle(1, 0);
    chk("t1_ks_data", 32'(ks_data), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);

    // T2: packing order and framing
    got_q.delete();
    step(0, 1, 9, 0, 0, 0, 0, 1);
    junk(1); junk(1);
    step(0, 0, 0, 1, SA, SB, SC, 1);
    idle(3, 1);
    step(0, 0, 0, 1, SA, SB, SC, 1);
    idle(15, 1);
    chk("t2_count", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < got_q.size(); i++) chk("t2_word", 32'(got_q[i]), 32'(t2_words[i]));
    chk("t2_busy", 32'(busy), 32'h0);

    // T3: backpressure, second back-to-back sample dropped
    step(0, 1, 100, 0, 0, 0, 0, 0);
    junk(0); junk(0);
    step(0, 0, 0, 1, SA, SB, SC, 0);
    step(0, 0, 0, 1, SA, SB, SC, 0);
    idle(2, 0);
    chk("t3_overflow", 32'(overflow), 32'h1);
    chk("t3_hold_data", 32'(ks_data), 32'hFF);
    chk("t3_hold_valid", 32'(ks_valid), 32'h1);
    got_q.delete();
    idle(12, 1);
    chk("t3_drained", 32'(got_q.size()), 32'd8);
    chk("t3_valid_low", 32'(ks_valid), 32'h0);

    // T5a: start while running is ignored
    step(0, 1, 5, 0, 0, 0, 0, 1);
    chk("t5_start_busy", 32'(busy), 32'h1);

    // T4: reach exactly one word pending, then fire and accept together
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < 20 && m_q.size() > 56; g++) idle(1, 1);
      junk(0);
      if (m_q.size() % OW == 0) break;
    end
    for (int g = 0; g < 100 && m_q.size() > OW; g++) idle(1, 1);
    step(0, 0, 0, 1, 32'h005A0000, $urandom, $urandom, 1);
    chk("t4_next_word", 32'(ks_data), 32'hB4);
    chk("t4_valid", 32'(ks_valid), 32'h1);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // T5b: zero-length start ignored
    step(0, 1, 0, 0, 0, 0, 0, 1);
    chk("t5_nb0_busy", 32'(busy), 32'h0);

    // T5c: reset mid-frame, then a clean frame
    got_q.delete();
    step(0, 1, 9, 0, 0, 0, 0, 1);
    junk(1); junk(1);
    step(0, 0, 0, 1, SA, SB, SC, 1);
    for (int g = 0; g < 20 && got_q.size() < 4; g++) idle(1, 1);
    step(1, 0, 0, 1, SA, SB, SC, 1);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_valid", 32'(ks_valid), 32'h0);
    chk("t5_rst_last", 32'(ks_last), 32'h0);
    chk("t5_rst_ovf", 32'(overflow), 32'h0);
    chk("t5_rst_data", 32'(ks_data), 32'h0);
    got_q.delete();
    step(0, 1, 9, 0, 0, 0, 0, 1);
    junk(1); junk(1);
    step(0, 0, 0, 1, SA, SB, SC, 1);
    idle(3, 1);
    step(0, 0, 0, 1, SA, SB, SC, 1);
    idle(15, 1);
    chk("t5_clean_count", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < got_q.size(); i++)
      chk("t5_clean_word", 32'(got_q[i]), 32'(t2_words[i]));
    chk("t5_clean_ovf", 32'(overflow), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 600) == 0, ($urandom % 15) == 0, int'($urandom_range(0, 12)),
           ($urandom % 3) == 0, $urandom, $urandom, $urandom, ($urandom % 4) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
